// File: rtl/core_sequencer_if.sv
// core_sequencer_if: shared memory port handshake (sequencer drives req/addr_sel/we, memory drives ready)
interface core_sequencer_if;
  logic mem_req;
  logic mem_addr_sel;
  logic mem_we;
  logic mem_ready;
  modport master(output mem_req, mem_addr_sel, mem_we, input mem_ready);
  modport slave(input mem_req, mem_addr_sel, mem_we, output mem_ready);
endinterface

// File: rtl/core_sequencer.sv
// core_sequencer: RV32I multi-cycle control FSM; ports clk/reset, opcode/branch_taken in, mem port via interface, ir/rf/pc strobes, pc_sel, state, halt flags, retired count out
module core_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic                branch_taken,
  core_sequencer_if.master    mem,
  output logic                ir_load,
  output logic                rf_write,
  output logic                pc_write,
  output logic [1:0]          pc_sel,
  output logic [2:0]          state,
  output logic                halted,
  output logic                illegal,
  output logic                bus_error,
  output logic [RETIRE_W-1:0] retired
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
    OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
    OP_ALU_IMM = 7'b0010011, OP_ALU_REG = 7'b0110011, OP_SYSTEM = 7'b1110011;
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT} state_t;
  state_t state_q, next_state;
  logic [CW-1:0] ctr;
  logic taken_q, set_ill, set_bus, retire, tmo, legal, is_ld, is_st, is_br;
  assign is_ld = opcode == OP_LOAD;
  assign is_st = opcode == OP_STORE;
  assign is_br = opcode == OP_BRANCH;
  assign legal = opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
    OP_ALU_IMM, OP_ALU_REG, OP_SYSTEM};
  assign tmo = ctr == CW'(MEM_TIMEOUT - 1);
  assign state = state_q;
  assign halted = state_q == HALT;
  always_comb begin
    next_state = state_q;
    mem.mem_req = 1'b0;
    mem.mem_addr_sel = 1'b0;
    mem.mem_we = 1'b0;
    ir_load = 1'b0;
    rf_write = 1'b0;
    pc_write = 1'b0;
    pc_sel = 2'b00;
    set_ill = 1'b0;
    set_bus = 1'b0;
    retire = 1'b0;
    case (reset ? HALT : state_q)
      FETCH: begin
        mem.mem_req = 1'b1;
        ir_load = mem.mem_ready;
        set_bus = !mem.mem_ready && tmo;
        next_state = mem.mem_ready ? DECODE : tmo ? HALT : FETCH;
      end
      DECODE: begin
        set_ill = !legal;
        next_state = legal ? EXECUTE : HALT;
      end
      EXECUTE: next_state = (is_ld || is_st) ? MEM : opcode == OP_SYSTEM ? HALT : WRITEBACK;
      MEM: begin
        mem.mem_req = 1'b1;
        mem.mem_addr_sel = 1'b1;
        mem.mem_we = is_st;
        pc_write = mem.mem_ready && is_st;
        retire = mem.mem_ready && is_st;
        set_bus = !mem.mem_ready && tmo;
        next_state = mem.mem_ready ? (is_st ? FETCH : WRITEBACK) : tmo ? HALT : MEM;
      end
      WRITEBACK: begin
        pc_write = 1'b1;
        retire = 1'b1;
        rf_write = !is_br;
        pc_sel = opcode == OP_JAL ? 2'b01 : opcode == OP_JALR ? 2'b10 : (is_br && taken_q) ? 2'b01 : 2'b00;
        next_state = FETCH;
      end
      HALT: ;
      default: begin
        set_ill = 1'b1;
        next_state = HALT;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      ctr <= '0;
      taken_q <= 1'b0;
      illegal <= 1'b0;
      bus_error <= 1'b0;
      retired <= '0;
    end else begin
      state_q <= next_state;
      ctr <= (mem.mem_req && !mem.mem_ready && next_state == state_q) ? ctr + 1'b1 : '0;
      if (state_q == EXECUTE) taken_q <= branch_taken;
      illegal <= illegal | set_ill;
      bus_error <= bus_error | set_bus;
      if (retire) retired <= retired + 1'b1;
    end
  end
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed plus random instruction stream checked cycle by cycle against a per-instruction trace model
module tb_core_sequencer;
  localparam int TMO = 4;
  localparam int RW = 4;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
    OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
    OP_ALU_IMM = 7'b0010011, OP_ALU_REG = 7'b0110011, OP_SYSTEM = 7'b1110011;
  typedef struct packed {
    logic [2:0] st;
    logic req, sel, we, ir, rf, pcw;
    logic [1:0] pcs;
    logic hl, il, be;
    logic [RW-1:0] ret;
  } out_t;
  typedef struct packed {
    logic rdy;
    out_t o;
  } step_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic branch_taken = 1'b0;
  logic ir_load, rf_write, pc_write, halted, illegal, bus_error;
  logic [1:0] pc_sel;
  logic [2:0] state;
  logic [RW-1:0] retired;
  core_sequencer_if bus ();
  core_sequencer #(.MEM_TIMEOUT(TMO), .RETIRE_W(RW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken), .mem(bus.master),
    .ir_load(ir_load), .rf_write(rf_write), .pc_write(pc_write), .pc_sel(pc_sel), .state(state),
    .halted(halted), .illegal(illegal), .bus_error(bus_error), .retired(retired)
  );
  always #5 clk = ~clk;
  step_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  logic [RW-1:0] ret_m = '0;
  logic il_m = 1'b0, be_m = 1'b0, hl_m = 1'b0;
  logic [6:0] ops [9] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_ALU_IMM, OP_ALU_REG};
  function automatic out_t sample();
    return '{st: state, req: bus.mem_req, sel: bus.mem_addr_sel, we: bus.mem_we, ir: ir_load,
      rf: rf_write, pcw: pc_write, pcs: pc_sel, hl: halted, il: illegal, be: bus_error, ret: retired};
  endfunction
  task automatic check(input string tag, input out_t exp);
    out_t obs;
    obs = sample();
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic void push(input logic rdy, input logic [2:0] st, input logic req, input logic sel,
      input logic we, input logic ir, input logic rf, input logic pcw, input logic [1:0] pcs, input logic retire);
    q.push_back('{rdy, '{st, req, sel, we, ir, rf, pcw, pcs, hl_m, il_m, be_m, ret_m}});
    if (retire) ret_m = ret_m + 1'b1;
  endfunction
  function automatic void halt_for(input int n, input logic ill, input logic be);
    il_m = il_m | ill;
    be_m = be_m | be;
    hl_m = 1'b1;
    for (int i = 0; i < n; i++) push(0, 3'd5, 0, 0, 0, 0, 0, 0, 2'b00, 0);
  endfunction
  task automatic plan(input logic [6:0] op, input int fw, input int mw, input logic tk, input int hold);
    logic ld, st, br;
    opcode = op;
    branch_taken = tk;
    ld = op == OP_LOAD;
    st = op == OP_STORE;
    br = op == OP_BRANCH;
    for (int i = 0; i < fw && i < TMO; i++) push(0, 3'd0, 1, 0, 0, 0, 0, 0, 2'b00, 0);
    if (fw >= TMO) begin halt_for(hold, 0, 1); return; end
    push(1, 3'd0, 1, 0, 0, 1, 0, 0, 2'b00, 0);
    push(0, 3'd1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    if (!(op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_ALU_IMM,
        OP_ALU_REG, OP_SYSTEM})) begin halt_for(hold, 1, 0); return; end
    push(0, 3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    if (op == OP_SYSTEM) begin halt_for(hold, 0, 0); return; end
    if (ld || st) begin
      for (int i = 0; i < mw && i < TMO; i++) push(0, 3'd3, 1, 1, st, 0, 0, 0, 2'b00, 0);
      if (mw >= TMO) begin halt_for(hold, 0, 1); return; end
      push(1, 3'd3, 1, 1, st, 0, 0, st, 2'b00, st);
      if (st) return;
    end
    push(0, 3'd4, 0, 0, 0, 0, !br, 1,
      op == OP_JAL ? 2'b01 : op == OP_JALR ? 2'b10 : (br && tk) ? 2'b01 : 2'b00, 1);
  endtask
  task automatic run(input string name, input int n);
    step_t e;
    for (int i = 0; q.size() > 0 && (n < 0 || i < n); i++) begin
      e = q.pop_front();
      bus.mem_ready = e.rdy;
      @(negedge clk);
      check($sformatf("%s step %0d", name, i), e.o);
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset(input string name);
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    #2 check(name, '0);
    @(posedge clk);
    #1 reset = 1'b0;
    ret_m = '0;
    il_m = 1'b0;
    be_m = 1'b0;
    hl_m = 1'b0;
    q.delete();
  endtask
  initial begin
    bus.mem_ready = 1'b0;
    do_reset("reset");
    plan(OP_ALU_REG, 0, 0, 0, 0); run("alu_reg", -1);
    plan(OP_LOAD, 0, 3, 0, 0); run("load_wait3", -1);
    plan(OP_BRANCH, 1, 0, 1, 0); run("branch_taken", -1);
    plan(OP_BRANCH, 0, 0, 0, 0); run("branch_not", -1);
    plan(OP_JALR, 2, 0, 0, 0); run("jalr", -1);
    plan(OP_JAL, 0, 0, 1, 0); run("jal", -1);
    plan(OP_STORE, 3, 2, 0, 0); run("store", -1);
    for (int k = 0; k < 40; k++) begin
      plan(ops[$urandom_range(8, 0)], $urandom_range(3, 0), $urandom_range(3, 0), 1'($urandom_range(1, 0)), 0);
      run($sformatf("rand%0d", k), -1);
    end
    plan(OP_STORE, 0, 3, 0, 0); run("store_mid", 4);
    do_reset("reset_mid_store");
    for (int k = 0; k < 16; k++) begin
      plan(OP_ALU_REG, 0, 0, 0, 0); run("alu16", -1);
    end
    @(negedge clk);
    n_chk++;
    assert (retired === ret_m && ret_m === '0) else begin
      n_fail++;
      $error("FAIL retired_wrap: got %0d expected 0", retired);
    end
    @(posedge clk); #1;
    do_reset("reset2");
    plan(7'h7F, 0, 0, 0, 20); run("illegal", -1);
    do_reset("reset3");
    plan(OP_ALU_REG, 4, 0, 0, 5); run("fetch_timeout", -1);
    do_reset("reset4");
    plan(OP_LOAD, 1, 4, 0, 5); run("mem_timeout", -1);
    do_reset("reset5");
    plan(OP_SYSTEM, 0, 0, 0, 5); run("system", -1);
    do_reset("reset6");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
